// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, 33-cycle latency; DIV_ZERO_FAST_EN lets divide-by-zero finish in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        div_annul,
  output logic        div_ready,
  output logic [63:0] div_result
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] a_q, b_q, q_q, d_q;
  logic [32:0] r_q;
  logic        s_q, ready_q;
  logic [63:0] result_q;
  logic [33:0] r_sh, r_diff;
  logic [32:0] r_d;
  logic [31:0] q_d, quo, rem, a_abs, b_abs;
  logic [63:0] res_d;
  logic        go, zero_fast;
  always_comb begin
    go     = div_start & ~div_annul;
    a_abs  = (div_signed && div_a[31]) ? -div_a : div_a;
    b_abs  = (div_signed && div_b[31]) ? -div_b : div_b;
    r_sh   = {r_q, q_q[31]};
    r_diff = r_sh - {2'b00, d_q};
    r_d    = r_diff[33] ? r_sh[32:0] : r_diff[32:0];
    q_d    = {q_q[30:0], ~r_diff[33]};
    quo    = (s_q && (a_q[31] ^ b_q[31])) ? -q_d : q_d;
    rem    = (s_q && a_q[31]) ? -r_d[31:0] : r_d[31:0];
    res_d  = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quo};
  end
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (div_b == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      s_q      <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          a_q   <= div_a;
          b_q   <= div_b;
          s_q   <= div_signed;
          q_q   <= a_abs;
          d_q   <= b_abs;
          r_q   <= '0;
          cnt_q <= '0;
          state_q  <= zero_fast ? DONE : CALC;
          ready_q  <= zero_fast;
          result_q <= zero_fast ? {div_a, 32'hFFFF_FFFF} : result_q;
        end
        CALC: if (div_annul) state_q <= IDLE;
        else begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 6'd1;
          // last of the 32 iterations: publish the sign-corrected result
          if (cnt_q == 6'd31) begin
            state_q  <= DONE;
            ready_q  <= 1'b1;
            result_q <= res_d;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign div_ready  = ready_q;
  assign div_result = result_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on the rising edge.
REQ-002 The port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-003 The port div_start SHALL be an input, 1 bit wide: request from the hazard unit, held high while a DIV/DIVU sits in EX and div_ready is 0.
REQ-004 The port div_signed SHALL be an input, 1 bit wide: 1 selects DIV (signed), 0 selects DIVU.
REQ-005 The ports div_a and div_b SHALL be inputs, 32 bits each: dividend and divisor.
REQ-006 The port div_annul SHALL be an input, 1 bit wide: abort request, driven from the exception flush.
REQ-007 The port div_ready SHALL be an output, 1 bit wide: registered; result valid for exactly one cycle.
REQ-008 The port div_result SHALL be an output, 64 bits wide: registered; [63:32] is the remainder (HI) and [31:0] is the quotient (LO).

Function
REQ-009 The FSM SHALL have states IDLE, CALC and DONE, with a 6-bit iteration counter.
REQ-010 In IDLE, div_start=1 with div_annul=0 SHALL latch div_a, div_b and div_signed at the edge, load the operand magnitudes, clear the counter and go to CALC.
REQ-011 Inputs in CALC and DONE, div_start included, SHALL be ignored; operand changes after the latching edge SHALL have no effect.
REQ-012 CALC SHALL perform one restoring shift-subtract iteration per cycle on 32-bit magnitudes with a 33-bit partial remainder; after the 32nd iteration it SHALL go to DONE.
REQ-013 Latency: with the start cycle counted as C0, div_ready SHALL be high only in C33.
REQ-014 In DONE, div_ready=1 and div_result SHALL be valid; the next edge SHALL return to IDLE and drop div_ready.
REQ-015 div_result SHALL hold its value after DONE until the next accepted start.
REQ-016 Signed sign rules:
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend;
  - magnitudes use the two's complement absolute value.
REQ-017 0x80000000 / 0xFFFFFFFF (signed) SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-018 div_b=0 SHALL yield quotient 0xFFFFFFFF and remainder equal to the latched div_a, regardless of div_signed.
REQ-019 div_annul=1 in CALC or DONE SHALL force IDLE at the next edge, with div_ready low from that edge on and div_result unchanged.
REQ-020 div_annul=1 and div_start=1 in the same IDLE cycle SHALL NOT start a division.
REQ-021 A div_start held high through DONE SHALL start a new division only from the following IDLE cycle, giving back-to-back operation.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL go to IDLE with div_ready=0, div_result=0, the counter at 0 and the operand registers at 0, overriding all other inputs, including mid-CALC.
REQ-023 After rst is released, the first cycle SHALL accept div_start.

Configuration
REQ-024 With DIV_ZERO_FAST_EN defined, div_b=0 SHALL skip CALC and go directly to DONE, so div_ready is high in C1.
REQ-025 Without DIV_ZERO_FAST_EN, div_b=0 SHALL run all 32 iterations with div_ready in C33, and the result SHALL be overridden to the REQ-018 values.
REQ-026 Result values SHALL be identical with and without DIV_ZERO_FAST_EN.

Verification
REQ-027 Unsigned 100/7 -> div_ready only in C33, div_result = {0x00000002, 0x0000000E}.
REQ-028 Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000, one div_ready pulse.
REQ-030 div_a=0x12345678, div_b=0 -> {0x12345678, 0xFFFFFFFF}, ready in C1 (macro defined) or C33 (undefined).
REQ-031 div_annul pulsed in C10 -> no div_ready; a div_start in C12 gives ready in C45 with the correct result.
REQ-032 div_start held high continuously -> ready pulses in C33 and C67; rst asserted in C20 of a third run -> IDLE, div_ready=0, div_result=0.
